mem_arbiter: RTL and testbench

Shares one main-memory port between the instruction-cache refill path (read-only) and the data-cache path (read/write). The block grants one requester at a time and sequences the memory strobes. It returns read data and busywait to the winning side and stalls the loser. It sits between both cache controllers and the single main memory of the processor.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the instruction-cache refill path
// (read-only) and the data-cache path (read/write). One requester is granted at a time.
// The memory strobes are sequenced from registers. Read data is returned to the winning
// side, and the losing side is stalled through its busywait.
//
// Build option: define ARB_FIXED_PRIORITY_EN to make the data side win every tie. The
// default build uses round-robin, where a tie goes to the side that was not granted last.

module mem_arbiter #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              TIMEOUT
);

  // Wait counter is 8 bits wide and saturates, so the limit is compared at that width.
  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    StIdle,
    StIAcc,
    StDAcc,
    StIDone,
    StDDone
  } state_t;

  state_t            state_q, state_d;
  logic              last_dside_q, last_dside_d;  // 1: the last grant went to the data side
  logic              first_q, first_d;            // first cycle of an access
  logic [7:0]        count_q, count_d;
  logic              timeout_q, timeout_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0] d_readdata_q, d_readdata_d;

  logic i_req;
  logic d_req;
  logic grant_iside;
  logic grant_dside;

  // Arbitration between the two pending requests; only acted on in idle.
  always_comb begin
    i_req = I_READ;
    d_req = D_READ | D_WRITE;
`ifdef ARB_FIXED_PRIORITY_EN
    grant_dside = d_req;
`else
    grant_dside = d_req & (~i_req | ~last_dside_q);
`endif
    grant_iside = i_req & ~grant_dside;
  end

  // Next-state logic: grant, access sequencing, completion and timeout tracking.
  always_comb begin
    state_d         = state_q;
    last_dside_d    = last_dside_q;
    first_d         = first_q;
    count_d         = count_q;
    timeout_d       = timeout_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_iside) begin
          state_d       = StIAcc;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = I_ADDRESS;
          last_dside_d  = 1'b0;
          count_d       = 8'd0;
          first_d       = 1'b1;
        end else if (grant_dside) begin
          state_d         = StDAcc;
          // A write takes precedence when both data-side strobes are requested.
          mem_write_d     = D_WRITE;
          mem_read_d      = ~D_WRITE;
          mem_address_d   = D_ADDRESS;
          mem_writedata_d = D_WRITEDATA;
          last_dside_d    = 1'b1;
          count_d         = 8'd0;
          first_d         = 1'b1;
        end
      end

      StIAcc, StDAcc: begin
        first_d = 1'b0;
        // Memory raises busywait in the same cycle as the strobe, so the first
        // cycle's busywait cannot be trusted and completion waits one cycle.
        if (!first_q && !MEM_BUSYWAIT) begin
          if (mem_read_q) begin
            if (state_q == StIAcc) begin
              i_readdata_d = MEM_READDATA;
            end else begin
              d_readdata_d = MEM_READDATA;
            end
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = (state_q == StIAcc) ? StIDone : StDDone;
        end else begin
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          // Sticky flag only; the access keeps waiting for the memory.
          if (count_d == MaxWait) begin
            timeout_d = 1'b1;
          end
        end
      end

      StIDone, StDDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= StIdle;
      last_dside_q    <= 1'b1;
      first_q         <= 1'b0;
      count_q         <= 8'd0;
      timeout_q       <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      last_dside_q    <= last_dside_d;
      first_q         <= first_d;
      count_q         <= count_d;
      timeout_q       <= timeout_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
    end
  end

  // Busywaits drop only during the granted side's done cycle.
  always_comb begin
    I_BUSYWAIT = I_READ & (state_q != StIDone);
    D_BUSYWAIT = (D_READ | D_WRITE) & (state_q != StDDone);
  end

  assign I_READDATA    = i_readdata_q;
  assign D_READDATA    = d_readdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;
  assign TIMEOUT       = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner
// sequences (alternation, timeout, reset mid-access) and a randomized run against a
// transaction-level reference model.

module tb_mem_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;
  logic          timeout;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(MW)
  ) dut (
    .CLK          (clk),
    .RESET        (reset),
    .I_READ       (i_read),
    .I_ADDRESS    (i_address),
    .I_READDATA   (i_readdata),
    .I_BUSYWAIT   (i_busywait),
    .D_READ       (d_read),
    .D_WRITE      (d_write),
    .D_ADDRESS    (d_address),
    .D_WRITEDATA  (d_writedata),
    .D_READDATA   (d_readdata),
    .D_BUSYWAIT   (d_busywait),
    .MEM_READ     (mem_read),
    .MEM_WRITE    (mem_write),
    .MEM_ADDRESS  (mem_address),
    .MEM_WRITEDATA(mem_writedata),
    .MEM_READDATA (mem_readdata),
    .MEM_BUSYWAIT (mem_busywait),
    .TIMEOUT      (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One cycle of directed stimulus: busywaits are checked during the cycle,
  // registered outputs just after the following edge.
  typedef struct packed {
    logic          rst, ir, dr, dw, mbw;
    logic          ebi, ebd, emr, emw;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] eird, edrd;
  } vec_t;

  vec_t tbl[17];

  // Reference model state (transaction view: owner, age of access, done cycle).
  int            m_owner;  // 0 none, 1 instruction side, 2 data side
  bit            m_done, m_wr, m_last_d, m_to, m_mr, m_mw;
  int            m_age, m_wait, m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ird, m_drd;

  task automatic model_reset();
    m_owner = 0; m_done = 0; m_wr = 0; m_last_d = 1; m_to = 0; m_mr = 0; m_mw = 0;
    m_age = 0; m_wait = 0; m_cnt = 0; m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] db;
    logic [AW-1:0] exp_addr;
    int got;
    bit prev_mr, e_ibw, e_dbw, i_seen, d_seen, ireq, dreq, pick_d;

    db = 32'hDEADBEEF;
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_writedata = '0; mem_readdata = '0; mem_busywait = 0;
    tick(); tick();

    // ---------------- vector table ----------------
    //            rst ir dr dw mbw ebi ebd emr emw addr   ird   drd
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 6'h00, 32'h0, 32'h0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 6'h05, 32'h0, 32'h0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 6'h05, 32'h0, 32'h0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 6'h05, 32'h0, 32'h0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 6'h05, db,    32'h0};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 6'h05, db,    32'h0};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 6'h05, db,    32'h0};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1, 6'h3F, db,    32'h0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1, 6'h3F, db,    32'h0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 6'h3F, db,    32'h0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 6'h3F, db,    32'h0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 6'h3F, db,    32'h0};
    tbl[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1, 6'h3F, db,    32'h0};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1, 6'h3F, db,    32'h0};
    tbl[14] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 6'h3F, db,    32'h0};
    tbl[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 6'h3F, db,    32'h0};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 6'h3F, db,    32'h0};

    i_address = 6'h05; d_address = 6'h3F; d_writedata = 32'h12345678; mem_readdata = db;
    for (int k = 0; k < 17; k++) begin
      reset = tbl[k].rst; i_read = tbl[k].ir; d_read = tbl[k].dr; d_write = tbl[k].dw;
      mem_busywait = tbl[k].mbw;
      #1;
      chk($sformatf("tbl%0d_i_busywait", k), 64'(i_busywait), 64'(tbl[k].ebi));
      chk($sformatf("tbl%0d_d_busywait", k), 64'(d_busywait), 64'(tbl[k].ebd));
      tick();
      chk($sformatf("tbl%0d_mem_read", k), 64'(mem_read), 64'(tbl[k].emr));
      chk($sformatf("tbl%0d_mem_write", k), 64'(mem_write), 64'(tbl[k].emw));
      chk($sformatf("tbl%0d_mem_address", k), 64'(mem_address), 64'(tbl[k].eaddr));
      chk($sformatf("tbl%0d_i_readdata", k), 64'(i_readdata), 64'(tbl[k].eird));
      chk($sformatf("tbl%0d_d_readdata", k), 64'(d_readdata), 64'(tbl[k].edrd));
      chk($sformatf("tbl%0d_timeout", k), 64'(timeout), 64'(0));
      if (tbl[k].emw) chk($sformatf("tbl%0d_mem_writedata", k), 64'(mem_writedata),
                          64'(32'h12345678));
    end
    reset = 0; i_read = 0; d_read = 0; d_write = 0; mem_busywait = 0;

    // ---------------- alternation under ties ----------------
    pulse_reset();
    i_address = 6'h05; d_address = 6'h2A; i_read = 1; d_read = 1; mem_busywait = 0;
    got = 0; prev_mr = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick();
      if (mem_read && !prev_mr) begin
        exp_addr = (Fixed || (got % 2 == 1)) ? 6'h2A : 6'h05;
        chk($sformatf("alt_grant%0d_addr", got), 64'(mem_address), 64'(exp_addr));
        got++;
      end
      prev_mr = mem_read;
    end
    chk("alt_grant_count", 64'(got), 64'(4));
    i_read = 0; d_read = 0;
    tick(); tick(); tick();

    // ---------------- timeout ----------------
    pulse_reset();
    i_address = 6'h11; i_read = 1; mem_busywait = 0;
    tick();                                // grant
    mem_busywait = 1;
    for (int w = 1; w <= 6; w++) begin
      tick();
      chk($sformatf("to_wait%0d_timeout", w), 64'(timeout), 64'(w >= 4 ? 1 : 0));
      chk($sformatf("to_wait%0d_mem_read", w), 64'(mem_read), 64'(1));
    end
    mem_busywait = 0; mem_readdata = 32'hCAFEF00D;
    tick();
    chk("to_done_mem_read", 64'(mem_read), 64'(0));
    chk("to_done_i_readdata", 64'(i_readdata), 64'(32'hCAFEF00D));
    chk("to_done_timeout", 64'(timeout), 64'(1));
    chk("to_done_i_busywait", 64'(i_busywait), 64'(0));
    i_read = 0;
    tick(); tick();
    chk("to_idle_timeout", 64'(timeout), 64'(1));
    pulse_reset();
    chk("to_after_reset_timeout", 64'(timeout), 64'(0));

    // ---------------- reset in the middle of a data access ----------------
    d_read = 1; d_address = 6'h0C; mem_busywait = 0; mem_readdata = 32'hA5A5A5A5;
    tick();
    chk("rm_first_mem_read", 64'(mem_read), 64'(1));
    tick(); tick();
    chk("rm_first_d_readdata", 64'(d_readdata), 64'(32'hA5A5A5A5));
    chk("rm_first_d_busywait", 64'(d_busywait), 64'(0));
    d_read = 0;
    tick();
    d_read = 1; d_address = 6'h0D;
    tick();
    chk("rm_second_grant_addr", 64'(mem_address), 64'(6'h0D));
    i_read = 1; i_address = 6'h07; mem_busywait = 1;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rm_reset_mem_read", 64'(mem_read), 64'(0));
    chk("rm_reset_mem_write", 64'(mem_write), 64'(0));
    chk("rm_reset_d_readdata", 64'(d_readdata), 64'(0));
    d_read = 0; mem_busywait = 0; mem_readdata = 32'h5A5A5A5A;
    #1;
    chk("rm_idle_i_busywait", 64'(i_busywait), 64'(1));
    tick();
    chk("rm_i_grant_mem_read", 64'(mem_read), 64'(1));
    chk("rm_i_grant_addr", 64'(mem_address), 64'(6'h07));
    tick(); tick();
    chk("rm_i_readdata", 64'(i_readdata), 64'(32'h5A5A5A5A));
    chk("rm_i_busywait_done", 64'(i_busywait), 64'(0));
    i_read = 0;
    tick();

    // ---------------- randomized run against the reference model ----------------
    model_reset();
    i_seen = 0; d_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 59) == 0);
      if (i_read && (i_seen || $urandom_range(0, 19) == 0)) i_read = 0;
      else if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1; i_address = AW'($urandom_range(0, 63));
      end
      if ((d_read || d_write) && (d_seen || $urandom_range(0, 19) == 0)) begin
        d_read = 0; d_write = 0;
      end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        got = $urandom_range(0, 2);
        d_read = (got != 1); d_write = (got != 0);
        d_address = AW'($urandom_range(0, 63)); d_writedata = $urandom;
      end
      if (m_owner != 0 && !m_done) mem_busywait = (m_age < 1 + m_wait);
      else mem_busywait = 1'($urandom_range(0, 1));
      mem_readdata = $urandom;
      #1;
      e_ibw = i_read && !(m_done && m_owner == 1);
      e_dbw = (d_read || d_write) && !(m_done && m_owner == 2);
      chk("rnd_i_busywait", 64'(i_busywait), 64'(e_ibw));
      chk("rnd_d_busywait", 64'(d_busywait), 64'(e_dbw));
      i_seen = i_read && !e_ibw;
      d_seen = (d_read || d_write) && !e_dbw;

      if (reset) begin
        model_reset();
      end else if (m_done) begin
        m_done = 0; m_owner = 0;
      end else if (m_owner != 0) begin
        if (m_age >= 1 && !mem_busywait) begin
          m_mr = 0; m_mw = 0; m_done = 1;
          if (!m_wr) begin
            if (m_owner == 1) m_ird = mem_readdata;
            else m_drd = mem_readdata;
          end
        end else begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt == MW) m_to = 1;
        end
        m_age++;
      end else begin
        ireq = i_read; dreq = d_read || d_write;
        pick_d = dreq && (!ireq || Fixed || !m_last_d);
        if (ireq || dreq) begin
          m_age = 0; m_cnt = 0; m_wait = $urandom_range(0, 3);
          if (pick_d) begin
            m_owner = 2; m_last_d = 1; m_addr = d_address; m_wr = d_write;
            m_mw = d_write; m_mr = !d_write; m_wdata = d_writedata;
          end else begin
            m_owner = 1; m_last_d = 0; m_addr = i_address; m_wr = 0; m_mr = 1; m_mw = 0;
          end
        end
      end

      tick();
      chk("rnd_mem_read", 64'(mem_read), 64'(m_mr));
      chk("rnd_mem_write", 64'(mem_write), 64'(m_mw));
      chk("rnd_mem_address", 64'(mem_address), 64'(m_addr));
      chk("rnd_i_readdata", 64'(i_readdata), 64'(m_ird));
      chk("rnd_d_readdata", 64'(d_readdata), 64'(m_drd));
      chk("rnd_timeout", 64'(timeout), 64'(m_to));
      if (m_mw) chk("rnd_mem_writedata", 64'(mem_writedata), 64'(m_wdata));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
